// File: rtl/mips_alu_mdu.sv
// mips_alu_mdu: handshaked MIPS EX unit, registered single-cycle ALU plus iterative MUL/DIV with HI/LO.
// Optional `overflow` output for ADD/SUB/ADDI when MIPS_ALU_OVF_TRAP_EN is defined.
module mips_alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func_field,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             div0
`ifdef MIPS_ALU_OVF_TRAP_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state;
    logic [WIDTH-1:0] hi, lo, ph, pl, m, alu, sum, dif, abs_a, abs_b, nh, nl, fin_hi, fin_lo;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, dz, sgn, ill, accept;
    logic [1:0] kind;
    logic [WIDTH:0] mul_s, div_t;
    logic [2*WIDTH-1:0] mp;

    assign sum = A + B;
    assign dif = A - B;
    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept = in_valid & in_ready;

    // kind: 0 single-cycle, 1 multiply, 2 divide
    always_comb begin
        alu = '0;
        ill = 1'b0;
        kind = 2'd0;
        sgn = 1'b0;
        if (opcode == 6'h00)
            case (func_field)
                6'h20, 6'h21: alu = sum;
                6'h22, 6'h23: alu = dif;
                6'h24: alu = A & B;
                6'h25: alu = A | B;
                6'h26: alu = A ^ B;
                6'h27: alu = ~(A | B);
                6'h2A: alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
                6'h2B: alu = {{(WIDTH-1){1'b0}}, A < B};
                6'h18: begin kind = 2'd1; sgn = 1'b1; end
                6'h19: kind = 2'd1;
                6'h1A: begin kind = 2'd2; sgn = 1'b1; end
                6'h1B: kind = 2'd2;
                6'h10: alu = hi;
                6'h12: alu = lo;
                default: ill = 1'b1;
            endcase
        else
            case (opcode)
                6'h23, 6'h2B, 6'h08, 6'h09: alu = sum;
                6'h04, 6'h05: alu = dif;
                6'h0C: alu = A & B;
                6'h0D: alu = A | B;
                6'h0E: alu = A ^ B;
                6'h0A: alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
                6'h0B: alu = {{(WIDTH-1){1'b0}}, A < B};
                default: ill = 1'b1;
            endcase
    end

    assign abs_a = (sgn & A[WIDTH-1]) ? -A : A;
    assign abs_b = (sgn & B[WIDTH-1]) ? -B : B;

    // Multiply: {ph,pl} shifts right, adding m into the top when the low bit is set.
    // Divide: restoring, ph is the partial remainder, pl shifts dividend out / quotient in.
    assign mul_s = {1'b0, ph} + (pl[0] ? {1'b0, m} : '0);
    assign div_t = {ph, pl[WIDTH-1]} - {1'b0, m};
    assign nh = (state == MUL) ? mul_s[WIDTH:1] : div_t[WIDTH] ? {ph[WIDTH-2:0], pl[WIDTH-1]} : div_t[WIDTH-1:0];
    assign nl = (state == MUL) ? {mul_s[0], pl[WIDTH-1:1]} : {pl[WIDTH-2:0], ~div_t[WIDTH]};
    assign mp = -{nh, nl};
    assign fin_hi = (state == MUL) ? (neg_q ? mp[2*WIDTH-1:WIDTH] : nh) : (neg_r ? -nh : nh);
    assign fin_lo = dz ? '1 : neg_q ? -nl : nl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            result <= '0;
            zero <= 1'b0;
            illegal <= 1'b0;
            div0 <= 1'b0;
            hi <= '0;
            lo <= '0;
            ph <= '0;
            pl <= '0;
            m <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
        end else begin
            if (out_valid & out_ready) out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept && kind == 2'd0) begin
                    out_valid <= 1'b1;
                    result <= alu;
                    zero <= alu == '0;
                    illegal <= ill;
                    div0 <= 1'b0;
                end else if (accept) begin
                    state <= (kind == 2'd1) ? MUL : DIV;
                    ph <= '0;
                    pl <= (kind == 2'd1) ? abs_b : abs_a;
                    m <= (kind == 2'd1) ? abs_a : abs_b;
                    cnt <= CW'(WIDTH - 1);
                    neg_q <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r <= sgn & A[WIDTH-1];
                    dz <= (kind == 2'd2) && (B == '0);
                end
            end else begin
                ph <= nh;
                pl <= nl;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    state <= IDLE;
                    hi <= fin_hi;
                    lo <= fin_lo;
                    out_valid <= 1'b1;
                    result <= fin_lo;
                    zero <= fin_lo == '0;
                    illegal <= 1'b0;
                    div0 <= dz;
                end
            end
        end
    end

`ifdef MIPS_ALU_OVF_TRAP_EN
    logic ovf;
    assign ovf = (((opcode == 6'h00 && func_field == 6'h20) || opcode == 6'h08) &&
                  A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1]) ||
                 (opcode == 6'h00 && func_field == 6'h22 &&
                  A[WIDTH-1] != B[WIDTH-1] && dif[WIDTH-1] != A[WIDTH-1]);
    always_ff @(posedge clk) begin
        if (!rst_n) overflow <= 1'b0;
        else if (accept) overflow <= ovf;
    end
`endif
endmodule

// File: tb/tb_mips_alu_mdu.sv
// tb_mips_alu_mdu: directed vectors with a result scoreboard for mips_alu_mdu (WIDTH 32).
module tb_mips_alu_mdu;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, zero, illegal, div0;
    logic [5:0] opcode = '0, func_field = '0;
    logic [31:0] A = '0, B = '0, result;
    int checks = 0, errors = 0;
`ifdef MIPS_ALU_OVF_TRAP_EN
    logic overflow;
`endif

    typedef struct {
        logic [31:0] r;
        logic        z, il, d0;
        string       nm;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mips_alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func_field(func_field), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .div0(div0)
`ifdef MIPS_ALU_OVF_TRAP_EN
        , .overflow(overflow)
`endif
    );

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got r=%h with nothing expected", result);
            end else begin
                e = q.pop_front();
                if ({result, zero, illegal, div0} !== {e.r, e.z, e.il, e.d0}) begin
                    errors++;
                    $display("FAIL %s: got r=%h z=%b il=%b d0=%b want r=%h z=%b il=%b d0=%b",
                             e.nm, result, zero, illegal, div0, e.r, e.z, e.il, e.d0);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input logic il,
                        input logic d0, input string nm);
        exp_t e;
        int n = 0;
        e.r = r; e.z = (r == 0); e.il = il; e.d0 = d0; e.nm = nm;
        q.push_back(e);
        opcode = op; func_field = fn; A = a; B = b; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: in_ready timeout", nm);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {29'b0, zero, illegal, div0}, 0);
        chk("reset_in_ready", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(6'h00, 6'h20, 32'h2222, 32'h1111, 32'h3333, 0, 0, "add");
        send(6'h04, 6'h00, 32'h5555, 32'h5555, 32'h0, 0, 0, "beq");
        send(6'h00, 6'h2A, 32'h1111, 32'h2222, 32'h1, 0, 0, "slt");
        send(6'h00, 6'h23, 32'h1, 32'h2, 32'hFFFFFFFF, 0, 0, "subu");
        send(6'h00, 6'h24, 32'hF0F0, 32'h0FF0, 32'h00F0, 0, 0, "and");
        send(6'h00, 6'h25, 32'hF0F0, 32'h0FF0, 32'hFFF0, 0, 0, "or");
        send(6'h00, 6'h26, 32'hF0F0, 32'h0FF0, 32'hFF00, 0, 0, "xor");
        send(6'h00, 6'h27, 32'hF0F0, 32'h0FF0, 32'hFFFF000F, 0, 0, "nor");
        send(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, "sltu");
        send(6'h0A, 6'h00, 32'hFFFFFFFE, 32'h1, 32'h1, 0, 0, "slti");
        send(6'h0B, 6'h00, 32'hFFFFFFFE, 32'h1, 32'h0, 0, 0, "sltiu");
        send(6'h0D, 6'h00, 32'h1200, 32'h0034, 32'h1234, 0, 0, "ori");
        send(6'h0E, 6'h00, 32'hFF, 32'h0F, 32'hF0, 0, 0, "xori");
        send(6'h23, 6'h00, 32'h1000, 32'h20, 32'h1020, 0, 0, "lw");
        send(6'h3F, 6'h00, 32'h1, 32'h2, 32'h0, 1, 0, "illegal_op");
        send(6'h00, 6'h3F, 32'h1, 32'h2, 32'h0, 1, 0, "illegal_fn");

        send(6'h00, 6'h18, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 0, 0, "mult");
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("mult_busy_cycles", n, 32);
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, "mfhi_mult");
        send(6'h00, 6'h12, 32'h0, 32'h0, 32'hFFFFFFEB, 0, 0, "mflo_mult");
        send(6'h00, 6'h19, 32'h10000, 32'h10000, 32'h0, 0, 0, "multu");
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'h1, 0, 0, "mfhi_multu");
        send(6'h00, 6'h1A, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0, 0, "div");
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, "mfhi_div");
        send(6'h00, 6'h1B, 32'h5, 32'h0, 32'hFFFFFFFF, 0, 1, "divu_by0");
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'h5, 0, 0, "mfhi_div0");
        send(6'h00, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, "div_minneg");
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'h0, 0, 0, "mfhi_minneg");
        send(6'h00, 6'h1A, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, "div_negb");
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'h1, 0, 0, "mfhi_negb");

`ifdef MIPS_ALU_OVF_TRAP_EN
        send(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, "add_ovf");
        chk("overflow_flag", {31'b0, overflow}, 1);
        send(6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, "addu_noovf");
        chk("overflow_addu", {31'b0, overflow}, 0);
`endif

        @(posedge clk); #1;
        out_ready = 1'b0;
        send(6'h00, 6'h20, 32'h10, 32'h20, 32'h30, 0, 0, "add_held");
        repeat (5) begin
            chk("hold_state", {out_valid, in_ready, result[29:0]}, {2'b10, 30'h30});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;

        opcode = 6'h00; func_field = 6'h18; A = 32'h3; B = 32'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midmul_reset_out_valid", {31'b0, out_valid}, 0);
        chk("midmul_reset_in_ready", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        send(6'h00, 6'h10, 32'h0, 32'h0, 32'h0, 0, 0, "mfhi_after_reset");
        send(6'h00, 6'h12, 32'h0, 32'h0, 32'h0, 0, 0, "mflo_after_reset");

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never appeared", q.size());
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
